trace_capture_fifo: RTL and testbench

Captures the CPU trace stream (trace_valid/trace_data) out of the picorv32 wrapper into an on-chip buffer. Each accepted word is tagged with a cycle timestamp, so BSW kernel runs can be profiled without a multi-GB trace file. The drain side is a valid/ready stream that feeds a host-readout or file-writer stage. Capture freezes a programmable number of cycles after trap, which preserves the instructions leading up to the trap.

---
 rtl/trace_pkg.sv | 25 ++
 rtl/trace_capture_fifo_if.sv | 21 ++
 rtl/sync_fifo_fwft.sv | 64 ++++++
 rtl/trace_capture_fifo.sv | 128 ++++++++++++
 tb/tb_trace_capture_fifo.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/trace_pkg.sv
// Shared definitions for the picorv32 trace capture path: widths, trace flag
// positions, the stored entry layout and the trap FSM encoding.
package trace_pkg;

   localparam int TRACE_W        = 36;
   localparam int TRACE_IRQ_BIT  = 35;
   localparam int TRACE_BR_BIT   = 34;
   localparam int TRACE_ADDR_BIT = 33;
   localparam int TRACE_RSVD_BIT = 32;

   localparam int TS_W_DEF   = 16;
   localparam int DROP_W_DEF = 16;

   typedef struct packed {
      logic [TS_W_DEF-1:0] ts;
      logic [TRACE_W-1:0]  data;
   } trace_entry_t;

   typedef enum logic [1:0] {
      TRAP_IDLE,
      TRAP_ARMED,
      TRAP_FROZEN
   } trap_state_t;

endpackage

// File: rtl/trace_capture_fifo_if.sv
// Trace ingress and timestamped drain stream of the capture buffer.
interface trace_capture_fifo_if #(
   parameter int TRACE_W = 36,
   parameter int TS_W    = 16
);
   logic                    trace_valid;
   logic [TRACE_W-1:0]      trace_data;
   logic                    out_valid;
   logic                    out_ready;
   logic [TS_W+TRACE_W-1:0] out_data;

   modport master (
      output trace_valid, trace_data, out_ready,
      input  out_valid, out_data
   );

   modport slave (
      input  trace_valid, trace_data, out_ready,
      output out_valid, out_data
   );
endinterface

// File: rtl/sync_fifo_fwft.sv
// Generic first-word-fall-through FIFO. The caller only pushes when !full or
// popping, and only pops when !empty.
module sync_fifo_fwft #(
   parameter int DEPTH = 256,
   parameter int WIDTH = 52
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    flush,
   input  logic                    push,
   input  logic                    pop,
   input  logic [WIDTH-1:0]        wdata,
   output logic [WIDTH-1:0]        rdata,
   output logic [$clog2(DEPTH):0]  level,
   output logic                    full,
   output logic                    empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW-1:0]    rd_addr;
   logic [AW:0]      level_reg;
   logic [WIDTH-1:0] head_reg;
   logic             head_bypass;

   // The head register is fetched from the address that will be the head next
   // cycle; a write landing on that same address is forwarded directly.
   always_comb begin
      rd_addr     = rd_ptr_reg + AW'(pop);
      head_bypass = push && (wr_ptr_reg == rd_addr);
   end

   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem[wr_ptr_reg] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
         head_reg   <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         level_reg <= level_reg + (AW+1)'(push) - (AW+1)'(pop);
         head_reg  <= head_bypass ? wdata : mem[rd_addr];
      end
   end

   assign level = level_reg;
   assign full  = (level_reg == (AW+1)'(DEPTH));
   assign empty = (level_reg == '0);
   assign rdata = empty ? '0 : head_reg;

endmodule

// File: rtl/trace_capture_fifo.sv
// Timestamped trace capture buffer with drop accounting and a post-trap
// freeze so the instructions leading up to a trap are preserved.
module trace_capture_fifo #(
   parameter int DEPTH     = 256,
   parameter int TRACE_W   = trace_pkg::TRACE_W,
   parameter int TS_W      = trace_pkg::TS_W_DEF,
   parameter int POST_TRAP = 64,
   parameter int DROP_W    = trace_pkg::DROP_W_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   input  logic                   clear,
   input  logic                   trap,
   trace_capture_fifo_if.slave    bus,
   output logic [$clog2(DEPTH):0] level,
   output logic [DROP_W-1:0]      drop_count,
   output logic                   overflow,
   output logic                   frozen
);
   import trace_pkg::*;

   localparam int CNT_W = (POST_TRAP < 2) ? 1 : $clog2(POST_TRAP + 1);

   trap_state_t       state_reg, state_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic [TS_W-1:0]   ts_reg;
   logic [DROP_W-1:0] drop_reg;
   logic              overflow_reg;
   logic              trap_q_reg;
   logic              trap_edge;
   logic              edge_block;
   logic              push_req;
   logic              pop;
   logic              push_ok;
   logic              drop;
   logic              fifo_full;
   logic              fifo_empty;

   assign trap_edge = trap && !trap_q_reg;

   // With no post-trap window the edge cycle itself is already blocked.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      edge_block = 1'b0;
      case (state_reg)
         TRAP_IDLE: begin
            if (trap_edge) begin
               if (POST_TRAP == 0) begin
                  state_next = TRAP_FROZEN;
                  edge_block = 1'b1;
               end else begin
                  state_next = TRAP_ARMED;
                  cnt_next   = CNT_W'(POST_TRAP);
               end
            end
         end
         TRAP_ARMED: begin
            cnt_next = cnt_reg - CNT_W'(1);
            if (cnt_reg == CNT_W'(1)) begin
               state_next = TRAP_FROZEN;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      frozen   = (state_reg == TRAP_FROZEN);
      push_req = bus.trace_valid && enable && !frozen && !edge_block;
      pop      = bus.out_valid && bus.out_ready;
      push_ok  = push_req && (!fifo_full || pop);
      drop     = push_req && fifo_full && !pop;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ts_reg       <= '0;
         trap_q_reg   <= 1'b0;
         state_reg    <= TRAP_IDLE;
         cnt_reg      <= '0;
         drop_reg     <= '0;
         overflow_reg <= 1'b0;
      end else if (clear) begin
         ts_reg       <= '0;
         trap_q_reg   <= trap;
         state_reg    <= TRAP_IDLE;
         cnt_reg      <= '0;
         drop_reg     <= '0;
         overflow_reg <= 1'b0;
      end else begin
         trap_q_reg <= trap;
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         if (enable) begin
            ts_reg <= ts_reg + TS_W'(1);
         end
         if (drop) begin
            overflow_reg <= 1'b1;
            if (!(&drop_reg)) begin
               drop_reg <= drop_reg + DROP_W'(1);
            end
         end
      end
   end

   sync_fifo_fwft #(
      .DEPTH (DEPTH),
      .WIDTH (TS_W + TRACE_W)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (clear),
      .push  (push_ok && !clear),
      .pop   (pop && !clear),
      .wdata ({ts_reg, bus.trace_data}),
      .rdata (bus.out_data),
      .level (level),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign bus.out_valid = !fifo_empty;
   assign drop_count    = drop_reg;
   assign overflow      = overflow_reg;

endmodule

// File: tb/tb_trace_capture_fifo.sv
// Bench for trace_capture_fifo: DUT A (DEPTH=8, POST_TRAP=4, TS_W=16) against a
// queue-based reference model, DUT B (DEPTH=32, POST_TRAP=0, TS_W=4) directed.
module tb_trace_capture_fifo;
   import trace_pkg::*;

   localparam int DA  = 8;
   localparam int PTA = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int tests_run    = 0;
   int tests_failed = 0;

   logic        rst_a = 1'b0, en_a = 1'b0, clr_a = 1'b0, trap_a = 1'b0;
   logic [3:0]  level_a;
   logic [15:0] drop_a;
   logic        ovf_a, frz_a;
   trace_capture_fifo_if #(.TRACE_W(36), .TS_W(16)) bus_a ();

   logic        rst_b = 1'b0, en_b = 1'b0, clr_b = 1'b0, trap_b = 1'b0;
   logic [5:0]  level_b;
   logic [15:0] drop_b;
   logic        ovf_b, frz_b;
   trace_capture_fifo_if #(.TRACE_W(36), .TS_W(4)) bus_b ();

   trace_capture_fifo #(.DEPTH(DA), .TRACE_W(36), .TS_W(16), .POST_TRAP(PTA), .DROP_W(16)) dut_a (
      .clk(clk), .reset(rst_a), .enable(en_a), .clear(clr_a), .trap(trap_a), .bus(bus_a),
      .level(level_a), .drop_count(drop_a), .overflow(ovf_a), .frozen(frz_a));

   trace_capture_fifo #(.DEPTH(32), .TRACE_W(36), .TS_W(4), .POST_TRAP(0), .DROP_W(16)) dut_b (
      .clk(clk), .reset(rst_b), .enable(en_b), .clear(clr_b), .trap(trap_b), .bus(bus_b),
      .level(level_b), .drop_count(drop_b), .overflow(ovf_b), .frozen(frz_b));

   // Reference model for DUT A: contents as a queue, freeze expressed as the
   // number of cycles elapsed since the first trap edge.
   logic [51:0] m_q[$];
   int          m_ts, m_drops, m_since;
   bit          m_ovf, m_edge_seen, m_trap_prev;

   function automatic void model_flush(bit trp_prev);
      m_q.delete();
      m_ts = 0; m_drops = 0; m_ovf = 0;
      m_edge_seen = 0; m_since = 0;
      m_trap_prev = trp_prev;
   endfunction

   function automatic void model_update(bit rst, bit tv, logic [35:0] td, bit en, bit clr, bit trp, bit rdy);
      int  sz;
      bit  pop, edge_now, cap_ok, req;
      if (rst) begin model_flush(0); return; end
      if (clr) begin model_flush(trp); return; end
      sz = m_q.size();
      pop = (sz != 0) && rdy;
      edge_now = trp && !m_trap_prev && !m_edge_seen;
      if (edge_now) begin m_edge_seen = 1; m_since = 0; end
      cap_ok = !m_edge_seen || ((m_since == 0) ? (PTA > 0) : (m_since <= PTA));
      req = tv && en && cap_ok;
      if (pop) void'(m_q.pop_front());
      if (req) begin
         if (sz < DA || pop) m_q.push_back({16'(m_ts), td});
         else begin
            m_ovf = 1;
            if (m_drops < 65535) m_drops++;
         end
      end
      if (en) m_ts = (m_ts + 1) % 65536;
      if (m_edge_seen) m_since++;
      m_trap_prev = trp;
   endfunction

   function automatic bit          exp_valid();  return m_q.size() != 0; endfunction
   function automatic logic [51:0] exp_data();   return (m_q.size() != 0) ? m_q[0] : 52'd0; endfunction
   function automatic logic [3:0]  exp_level();  return 4'(m_q.size()); endfunction
   function automatic bit          exp_frozen(); return m_edge_seen && (m_since > PTA); endfunction

   task automatic step_a(input bit rst, input bit tv, input logic [35:0] td, input bit en,
                         input bit clr, input bit trp, input bit rdy);
      rst_a = rst; bus_a.trace_valid = tv; bus_a.trace_data = td; en_a = en;
      clr_a = clr; trap_a = trp; bus_a.out_ready = rdy;
      @(negedge clk);
      model_update(rst, tv, td, en, clr, trp, rdy);
      @(posedge clk);
      #1;
   endtask

   task automatic step_b(input bit rst, input bit tv, input logic [35:0] td, input bit en,
                         input bit clr, input bit trp, input bit rdy);
      rst_b = rst; bus_b.trace_valid = tv; bus_b.trace_data = td; en_b = en;
      clr_b = clr; trap_b = trp; bus_b.out_ready = rdy;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      step_a(1, 0, 36'd0, 0, 0, 0, 0);
      step_a(1, 1, 36'h5, 1, 0, 0, 1);
      tests_run++;
      if (bus_a.out_valid !== 1'b0 || bus_a.out_data !== 52'd0 || level_a !== 4'd0 ||
          drop_a !== 16'd0 || ovf_a !== 1'b0 || frz_a !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_state: valid=%b data=%h level=%0d drop=%0d ovf=%b frz=%b, want all 0",
                  bus_a.out_valid, bus_a.out_data, level_a, drop_a, ovf_a, frz_a);
      end
   endtask

   task automatic test_first_word();
      step_a(1, 0, 36'd0, 1, 0, 0, 0);
      for (int k = 0; k < 5; k++) step_a(0, 0, 36'd0, 1, 0, 0, 0);
      step_a(0, 1, 36'h000000011, 1, 0, 0, 0);
      tests_run++;
      if (bus_a.out_valid !== 1'b1 || bus_a.out_data !== {16'd5, 36'h000000011} || level_a !== 4'd1) begin
         tests_failed++;
         $display("FAIL first_word: valid=%b data=%h level=%0d, want 1 %h 1",
                  bus_a.out_valid, bus_a.out_data, level_a, {16'd5, 36'h000000011});
      end
      step_a(1, 0, 36'd0, 1, 0, 0, 0);
      tests_run++;
      if (bus_a.out_valid !== 1'b0 || bus_a.out_data !== 52'd0 || level_a !== 4'd0 ||
          drop_a !== 16'd0 || ovf_a !== 1'b0 || frz_a !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_after_word: valid=%b data=%h level=%0d drop=%0d ovf=%b frz=%b, want all 0",
                  bus_a.out_valid, bus_a.out_data, level_a, drop_a, ovf_a, frz_a);
      end
   endtask

   task automatic test_overflow_drain();
      logic [35:0] pd [10];
      step_a(1, 0, 36'd0, 1, 0, 0, 0);
      for (int k = 0; k < 10; k++) begin
         pd[k] = {4'($urandom_range(15, 0)), 32'($urandom())};
         step_a(0, 1, pd[k], 1, 0, 0, 0);
      end
      tests_run++;
      if (level_a !== 4'd8 || drop_a !== 16'd2 || ovf_a !== 1'b1) begin
         tests_failed++;
         $display("FAIL overflow_counts: level=%0d drop=%0d ovf=%b, want 8 2 1", level_a, drop_a, ovf_a);
      end
      for (int k = 0; k < 8; k++) begin
         tests_run++;
         if (bus_a.out_valid !== 1'b1 || bus_a.out_data !== {16'(k), pd[k]}) begin
            tests_failed++;
            $display("FAIL drain_order[%0d]: valid=%b data=%h, want 1 %h",
                     k, bus_a.out_valid, bus_a.out_data, {16'(k), pd[k]});
         end
         step_a(0, 0, 36'd0, 1, 0, 0, 1);
      end
      tests_run++;
      if (bus_a.out_valid !== 1'b0 || level_a !== 4'd0) begin
         tests_failed++;
         $display("FAIL drain_empty: valid=%b level=%0d, want 0 0", bus_a.out_valid, level_a);
      end
   endtask

   task automatic test_full_push_pop();
      step_a(1, 0, 36'd0, 1, 0, 0, 0);
      for (int k = 0; k < 8; k++) step_a(0, 1, 36'h200 + 36'(k), 1, 0, 0, 0);
      step_a(0, 1, 36'h2ff, 1, 0, 0, 1);
      tests_run++;
      if (level_a !== 4'd8 || drop_a !== 16'd0 || bus_a.out_data !== {16'd1, 36'h201}) begin
         tests_failed++;
         $display("FAIL full_push_pop: level=%0d drop=%0d head=%h, want 8 0 %h",
                  level_a, drop_a, bus_a.out_data, {16'd1, 36'h201});
      end
      for (int k = 0; k < 8; k++) begin
         tests_run++;
         if (bus_a.out_valid !== exp_valid() || bus_a.out_data !== exp_data() || level_a !== exp_level()) begin
            tests_failed++;
            $display("FAIL full_drain[%0d]: valid=%b data=%h level=%0d, want %b %h %0d",
                     k, bus_a.out_valid, bus_a.out_data, level_a, exp_valid(), exp_data(), exp_level());
         end
         step_a(0, 0, 36'd0, 1, 0, 0, 1);
      end
   endtask

   task automatic test_trap_freeze();
      logic [35:0] got[$];
      bit trp;
      step_a(1, 0, 36'd0, 1, 0, 0, 1);
      for (int k = 0; k < 20; k++) begin
         trp = (k >= 3 && k < 6) || (k >= 10 && k < 12);
         if (bus_a.out_valid) got.push_back(bus_a.out_data[35:0]);
         step_a(0, 1, 36'h100 + 36'(k), 1, 0, trp, 1);
         if (k == 6 || k == 7) begin
            tests_run++;
            if (frz_a !== (k == 7)) begin
               tests_failed++;
               $display("FAIL frozen_timing k=%0d: frozen=%b, want %b", k, frz_a, (k == 7));
            end
         end
      end
      for (int k = 0; k < 3; k++) begin
         if (bus_a.out_valid) got.push_back(bus_a.out_data[35:0]);
         step_a(0, 0, 36'd0, 1, 0, 0, 1);
      end
      tests_run++;
      if (got.size() != 8 || frz_a !== 1'b1) begin
         tests_failed++;
         $display("FAIL trap_capture_count: got %0d words frozen=%b, want 8 words frozen=1", got.size(), frz_a);
      end
      for (int i = 0; i < got.size() && i < 8; i++) begin
         tests_run++;
         if (got[i] !== 36'h100 + 36'(i)) begin
            tests_failed++;
            $display("FAIL trap_capture[%0d]: got %h, want %h", i, got[i], 36'h100 + 36'(i));
         end
      end
      // Clear with trap held high: no edge afterwards, capture resumes.
      step_a(0, 1, 36'h55, 1, 1, 1, 0);
      tests_run++;
      if (frz_a !== 1'b0 || level_a !== 4'd0 || drop_a !== 16'd0 || bus_a.out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL trap_clear: frozen=%b level=%0d drop=%0d valid=%b, want 0 0 0 0",
                  frz_a, level_a, drop_a, bus_a.out_valid);
      end
      for (int k = 0; k < 6; k++) step_a(0, 1, 36'h300 + 36'(k), 1, 0, 1, 0);
      tests_run++;
      if (frz_a !== 1'b0 || level_a !== 4'd6 || bus_a.out_data !== {16'd0, 36'h300}) begin
         tests_failed++;
         $display("FAIL clear_trap_tracking: frozen=%b level=%0d head=%h, want 0 6 %h",
                  frz_a, level_a, bus_a.out_data, {16'd0, 36'h300});
      end
   endtask

   task automatic test_clear();
      step_a(1, 0, 36'd0, 1, 0, 0, 0);
      for (int k = 0; k < 10; k++) step_a(0, 1, 36'h400 + 36'(k), 1, 0, 0, 0);
      step_a(0, 1, 36'h4aa, 1, 1, 0, 0);
      tests_run++;
      if (level_a !== 4'd0 || drop_a !== 16'd0 || ovf_a !== 1'b0 || bus_a.out_valid !== 1'b0 ||
          bus_a.out_data !== 52'd0) begin
         tests_failed++;
         $display("FAIL clear_flush: level=%0d drop=%0d ovf=%b valid=%b data=%h, want all 0",
                  level_a, drop_a, ovf_a, bus_a.out_valid, bus_a.out_data);
      end
      step_a(0, 1, 36'h4bb, 1, 0, 0, 0);
      tests_run++;
      if (level_a !== 4'd1 || bus_a.out_data !== {16'd0, 36'h4bb}) begin
         tests_failed++;
         $display("FAIL clear_restart: level=%0d data=%h, want 1 %h", level_a, bus_a.out_data, {16'd0, 36'h4bb});
      end
   endtask

   task automatic test_random();
      bit trp = 0;
      bit tv, en, clr, rdy;
      logic [35:0] td;
      step_a(1, 0, 36'd0, 1, 0, 0, 0);
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(24, 0) == 0) trp = !trp;
         tv  = ($urandom_range(3, 0) != 0);
         en  = ($urandom_range(7, 0) != 0);
         clr = ($urandom_range(59, 0) == 0);
         rdy = ($urandom_range(2, 0) == 0);
         td  = {4'($urandom_range(15, 0)), 32'($urandom())};
         step_a(0, tv, td, en, clr, trp, rdy);
         tests_run++;
         if (bus_a.out_valid !== exp_valid() || bus_a.out_data !== exp_data() || level_a !== exp_level() ||
             drop_a !== 16'(m_drops) || ovf_a !== m_ovf || frz_a !== exp_frozen()) begin
            tests_failed++;
            $display("FAIL random[%0d]: valid=%b/%b data=%h/%h level=%0d/%0d drop=%0d/%0d ovf=%b/%b frz=%b/%b (got/want)",
                     k, bus_a.out_valid, exp_valid(), bus_a.out_data, exp_data(), level_a, exp_level(),
                     drop_a, m_drops, ovf_a, m_ovf, frz_a, exp_frozen());
         end
      end
   endtask

   task automatic test_ts_wrap();
      step_b(1, 0, 36'd0, 1, 0, 0, 0);
      for (int k = 0; k < 20; k++) step_b(0, 1, 36'(k), 1, 0, 0, 0);
      tests_run++;
      if (level_b !== 6'd20 || drop_b !== 16'd0 || ovf_b !== 1'b0) begin
         tests_failed++;
         $display("FAIL ts_wrap_fill: level=%0d drop=%0d ovf=%b, want 20 0 0", level_b, drop_b, ovf_b);
      end
      for (int k = 0; k < 20; k++) begin
         tests_run++;
         if (bus_b.out_valid !== 1'b1 || bus_b.out_data !== {4'(k % 16), 36'(k)}) begin
            tests_failed++;
            $display("FAIL ts_wrap[%0d]: valid=%b data=%h, want 1 %h",
                     k, bus_b.out_valid, bus_b.out_data, {4'(k % 16), 36'(k)});
         end
         step_b(0, 0, 36'd0, 1, 0, 0, 1);
      end
   endtask

   task automatic test_post_trap_zero();
      step_b(1, 0, 36'd0, 1, 0, 0, 0);
      step_b(0, 0, 36'd0, 1, 0, 0, 0);
      step_b(0, 1, 36'habc, 1, 0, 1, 0);
      tests_run++;
      if (level_b !== 6'd0 || frz_b !== 1'b1 || drop_b !== 16'd0 || bus_b.out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL post_trap_zero: level=%0d frozen=%b drop=%0d valid=%b, want 0 1 0 0",
                  level_b, frz_b, drop_b, bus_b.out_valid);
      end
      for (int k = 0; k < 3; k++) step_b(0, 1, 36'(k), 1, 0, 1, 0);
      tests_run++;
      if (level_b !== 6'd0 || drop_b !== 16'd0 || frz_b !== 1'b1) begin
         tests_failed++;
         $display("FAIL frozen_ignores_push: level=%0d drop=%0d frozen=%b, want 0 0 1", level_b, drop_b, frz_b);
      end
      step_b(0, 1, 36'h1, 1, 1, 1, 0);
      step_b(0, 1, 36'hdef, 1, 0, 1, 0);
      tests_run++;
      if (frz_b !== 1'b0 || level_b !== 6'd1 || bus_b.out_data !== {4'd0, 36'hdef}) begin
         tests_failed++;
         $display("FAIL post_trap_zero_clear: frozen=%b level=%0d data=%h, want 0 1 %h",
                  frz_b, level_b, bus_b.out_data, {4'd0, 36'hdef});
      end
   endtask

   initial begin
      bus_a.trace_valid = 1'b0; bus_a.trace_data = '0; bus_a.out_ready = 1'b0;
      bus_b.trace_valid = 1'b0; bus_b.trace_data = '0; bus_b.out_ready = 1'b0;
      model_flush(0);
      test_reset();
      test_first_word();
      test_overflow_drain();
      test_full_push_pop();
      test_trap_freeze();
      test_clear();
      test_random();
      test_ts_wrap();
      test_post_trap_zero();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
